threshold_fifo: RTL and testbench
=================================

Name: threshold_fifo

Overview:
- Per-lane synchronous FIFO with programmable almost-full and almost-empty flags.
- Eight instances form the lane buffer bank. Each instance's `empty` drives one bit of the bank's `empties[7:0]` vector for the power-state controller.
- That controller supplies `sup_threshold` and `inf_threshold`, which are already registered on its side.
- Registered read path; overflow and underflow are flagged with a sticky error.

Parameters:
- DATA_W, 6, payload width in bits.
- ADDR_W, 3, pointer width. DEPTH = 2**ADDR_W = 8 entries.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request; data_in is captured on the same edge.
- data_in  input  DATA_W  write payload.
- pop  input  1  read request.
- sup_threshold  input  ADDR_W  almost-full margin, in free slots.
- inf_threshold  input  ADDR_W  almost-empty level, in stored words.
- data_out  output  DATA_W  registered read payload.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- count  output  ADDR_W+1  stored words, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  (DEPTH - count) <= sup_threshold.
- almost_empty  output  1  count <= inf_threshold.
- error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (reset=1 at an edge), takes priority over everything:
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
  - Memory contents are not cleared.
  - Resulting flags: empty=1, full=0. almost_empty=1, since 0 <= any threshold. almost_full=0 unless sup_threshold >= 8, which is impossible with 3 bits.
- Reset mid-operation discards all stored words. The next edge after reset deasserts behaves as from an empty FIFO.
- Storage: DEPTH x DATA_W register array. wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH, so 7 -> 0 with no special case.
- Qualified operations:
  - wr_en = push & (~full | pop).
  - rd_en = pop & ~empty.
- Write: on wr_en, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read:
  - On rd_en: data_out <= mem[rd_ptr], rd_ptr increments, valid_out <= 1. Latency is one cycle from the pop edge to data_out.
  - When rd_en=0: valid_out <= 0 and data_out holds its last value.
- Count update, one edge:
  - wr_en & ~rd_en -> count+1.
  - rd_en & ~wr_en -> count-1.
  - both or neither -> unchanged.
- Simultaneous push and pop:
  - When full: both execute and count stays at DEPTH. The read uses the old rd_ptr and the write lands in the freed slot; no overflow.
  - When empty: the pop is an underflow and is ignored; the push executes and count becomes 1. The pushed word is not bypassed to data_out.
- Overflow: push & full & ~pop. The word is dropped, pointers are unchanged, and error <= 1.
- Underflow: pop & empty. Nothing is read, valid_out <= 0, and error <= 1.
- error stays at 1 until reset.
- Flags full, empty, almost_full and almost_empty are combinational from the registered count and the threshold inputs. A threshold change therefore affects the flags in the same cycle.
- Threshold arithmetic is unsigned at ADDR_W+1 bits:
  - sup_threshold=0 -> almost_full == full.
  - inf_threshold=0 -> almost_empty == empty.
- No internal state machine beyond the pointers and count. Pointer equality is never used to infer full or empty; count is the only source.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, valid_out=0, error=0.
- sup=2, inf=1. Push 0x01..0x08 on consecutive cycles:
  - almost_empty drops after the 2nd push.
  - almost_full rises after the 6th push, at count=6.
  - full=1 after the 8th push.
  - A 9th push alone -> count stays 8, error=1.
- From full with 0x01..0x08 stored: pop 8 consecutive cycles -> data_out = 0x01..0x08, each one cycle after its pop, with valid_out=1 throughout. Then empty=1 and valid_out=0 on the cycle after the last read.
- Wrap: push 5, pop 5, then push 6 (0x10..0x15) and pop 6 -> order preserved across pointer wrap, count returns to 0, error=0.
- Full, then push and pop together with data_in=0x2A -> count=8, error=0. Draining returns the old words then 0x2A last.
- Empty, then push and pop together with data_in=0x3F -> count=1, valid_out=0, error=1. The next pop returns 0x3F.
- Reset asserted while count=5 -> next cycle count=0, empty=1, error=0, valid_out=0.

Source files
------------

// File: rtl/threshold_fifo_if.sv
// rtl/threshold_fifo_if.sv - push/pop, threshold and status bundle for one lane FIFO
interface threshold_fifo_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [ADDR_W-1:0] sup_threshold;
  logic [ADDR_W-1:0] inf_threshold;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              error;

  modport master (
    output push, data_in, pop, sup_threshold, inf_threshold,
    input  data_out, valid_out, count, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  push, data_in, pop, sup_threshold, inf_threshold,
    output data_out, valid_out, count, full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/threshold_fifo.sv
// rtl/threshold_fifo.sv - lane FIFO with programmable almost-full/almost-empty flags
module threshold_fifo #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input logic           clk,
  input logic           reset,
  threshold_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              error_q;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic overflow;
  logic underflow;

  // Count is the single source of occupancy; pointers alone never decide full/empty.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_en     = bus.push & (~full | bus.pop);
  assign rd_en     = bus.pop & ~empty;
  assign overflow  = bus.push & full & ~bus.pop;
  assign underflow = bus.pop & empty;

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = ((DEPTH_C - count_q) <= {1'b0, bus.sup_threshold});
  assign bus.almost_empty = (count_q <= {1'b0, bus.inf_threshold});
  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.error        = error_q;

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // On a full push+pop the read sees the old word before the write refills that slot.
      if (rd_en) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      valid_q <= rd_en;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (overflow || underflow) begin
        error_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_threshold_fifo.sv
// tb/tb_threshold_fifo.sv - queue-model bench for threshold_fifo
module tb_threshold_fifo;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  threshold_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  threshold_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_err;
  logic [ADDR_W-1:0] sup_t;
  logic [ADDR_W-1:0] inf_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int n = q.size();
    check({ph, ":count"},        32'(bus.count),        32'(n));
    check({ph, ":empty"},        32'(bus.empty),        32'(n == 0));
    check({ph, ":full"},         32'(bus.full),         32'(n == DEPTH));
    check({ph, ":almost_full"},  32'(bus.almost_full),  32'((DEPTH - n) <= int'(sup_t)));
    check({ph, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= int'(inf_t)));
    check({ph, ":valid_out"},    32'(bus.valid_out),    32'(m_valid));
    check({ph, ":data_out"},     32'(bus.data_out),     32'(m_data));
    check({ph, ":error"},        32'(bus.error),        32'(m_err));
  endtask

  task automatic set_thr(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] i);
    sup_t = s;
    inf_t = i;
    bus.sup_threshold = s;
    bus.inf_threshold = i;
  endtask

  task automatic do_reset(input string ph);
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    @(posedge clk);
    #1;
    q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    check_all(ph);
    reset = 1'b0;
  endtask

  // Model from the FIFO rules: a pop reads only if something is stored,
  // a push is accepted if there is room before the edge or a pop accompanies it.
  task automatic cycle(input string ph, input logic p, input logic r, input logic [DATA_W-1:0] d);
    int  n;
    bit  do_rd;
    bit  do_wr;
    reset = 1'b0;
    bus.push = p;
    bus.pop = r;
    bus.data_in = d;
    n = q.size();
    do_rd = r && (n > 0);
    do_wr = p && ((n < DEPTH) || r);
    if ((p && n == DEPTH && !r) || (r && n == 0)) m_err = 1'b1;
    m_valid = do_rd;
    if (do_rd) m_data = q.pop_front();
    if (do_wr) q.push_back(d);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    set_thr(3'd2, 3'd1);
    q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_err = 1'b0;

    do_reset("reset");
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, '0);

    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, DATA_W'(i));
    cycle("overflow", 1'b1, 1'b0, 6'h09);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1, '0);
    cycle("drain_end", 1'b0, 1'b0, '0);

    do_reset("reset2");
    for (int i = 0; i < 5; i++) cycle("wrap_push5", 1'b1, 1'b0, DATA_W'(6'h20 + i));
    for (int i = 0; i < 5; i++) cycle("wrap_pop5", 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) cycle("wrap_push6", 1'b1, 1'b0, DATA_W'(6'h10 + i));
    for (int i = 0; i < 6; i++) cycle("wrap_pop6", 1'b0, 1'b1, '0);
    cycle("wrap_end", 1'b0, 1'b0, '0);

    for (int i = 0; i < 8; i++) cycle("full_fill", 1'b1, 1'b0, DATA_W'(6'h30 + i));
    cycle("full_pushpop", 1'b1, 1'b1, 6'h2A);
    for (int i = 0; i < 8; i++) cycle("full_drain", 1'b0, 1'b1, '0);
    cycle("full_drain_end", 1'b0, 1'b0, '0);

    cycle("empty_pushpop", 1'b1, 1'b1, 6'h3F);
    cycle("empty_pop", 1'b0, 1'b1, '0);
    cycle("empty_end", 1'b0, 1'b0, '0);

    do_reset("reset3");
    for (int i = 0; i < 5; i++) cycle("mid_push", 1'b1, 1'b0, DATA_W'(6'h05 + i));
    do_reset("mid_reset");
    cycle("after_reset", 1'b1, 1'b0, 6'h11);

    set_thr(3'd0, 3'd0);
    #1;
    check_all("thr_zero");
    for (int i = 0; i < 8; i++) cycle("thr_zero_fill", 1'b1, 1'b0, DATA_W'(i));
    set_thr(3'd7, 3'd7);
    #1;
    check_all("thr_max");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_thr(ADDR_W'($urandom), ADDR_W'($urandom));
        #1;
        check_all("rand_thr");
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_reset");
      end else begin
        cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
              DATA_W'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
